// File: rtl/uart_pkg.sv
// Shared types and parameter limits for the parametrised UART receiver.
//   rx_state_t : receiver FSM states
//   *_MIN/*_MAX: legal ranges for BAUD_DIV, DATA_BITS and STOP_BITS
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int unsigned BAUD_DIV_MIN  = 16;
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter for the UART receiver.
//   clk       in  system clock
//   sys_rst_n in  asynchronous active-low reset
//   load      in  load strobe, takes priority over counting
//   load_val  in  value loaded on the load strobe
//   expire    out one-cycle pulse, load_val cycles after the load cycle
module uart_baud_timer #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned CW       = $clog2(BAUD_DIV + 1)
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count is 1 so that the pulse lines up with the cycle in which
  // the counter would reach zero; a counter parked at zero never fires.
  assign expire = (cnt_q == CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: serial line to parallel word with ready/clear
// handshake, optional parity, 1-2 stop bits, parity/framing/overrun flags.
//   clk       in  system clock
//   sys_rst_n in  asynchronous active-low reset
//   uart_rx   in  serial input, idle high, asynchronous to clk
//   clr_rdy   in  consumer acknowledge, clears rdy and overrun
//   rx_data   out last received data word
//   rdy       out rx_data / par_err / frm_err valid
//   par_err   out parity mismatch in the held frame (0 when parity disabled)
//   frm_err   out a stop bit of the held frame was sampled low
//   overrun   out sticky, a frame completed while rdy was still high
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a high->low edge on the synchronised line
// ST_START  | half a bit in; confirm the start bit is still low
// ST_DATA   | sampling DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling STOP_BITS stop bits, then publishing the frame
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rx,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 overrun
);

  if (BAUD_DIV < BAUD_DIV_MIN) begin : g_bad_baud
    $error("uart_rx_param: BAUD_DIV=%0d below minimum %0d", BAUD_DIV, BAUD_DIV_MIN);
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
  end

  localparam int unsigned CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] T_FULL  = CW'(BAUD_DIV);
  localparam logic [CW-1:0] T_HALF  = CW'(BAUD_DIV / 2);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD    = 1'(PARITY_ODD);

  // Synchroniser and edge detector; all three idle high so reset never
  // looks like a start edge.
  logic sync1_q, sync2_q, prev_q;
  logic line, line_fall;

  assign line      = sync2_q;
  assign line_fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  logic          tmr_load, tmr_expire;
  logic [CW-1:0] tmr_val;

  uart_baud_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_timer (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expire    (tmr_expire)
  );

  rx_state_t            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_q, frm_d;
  logic                 frame_done;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frm_d      = frm_q;
    tmr_load   = 1'b0;
    tmr_val    = T_FULL;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (line_fall) begin
          state_d   = ST_START;
          tmr_load  = 1'b1;
          tmr_val   = T_HALF;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
          frm_d     = 1'b0;
        end
      end
      ST_START: begin
        if (tmr_expire) begin
          if (!line) begin
            state_d  = ST_DATA;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tmr_expire) begin
          shift_d  = {line, shift_q[DATA_BITS-1:1]};
          tmr_load = 1'b1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tmr_expire) begin
          par_bad_d = (line != ((^shift_q) ^ PAR_ODD));
          tmr_load  = 1'b1;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tmr_expire) begin
          if (!line) begin
            frm_d = 1'b1;
          end
          if (bit_cnt_q == LAST_STOP) begin
            frame_done = 1'b1;
            bit_cnt_d  = '0;
            state_d    = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tmr_load  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      frm_q     <= frm_d;
    end
  end

  // Output registers. frm_d already folds in the last stop sample.
  // Completion beats a simultaneous clr_rdy, and that clr_rdy then leaves
  // overrun alone.
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    overrun_d = overrun_q;
    if (frame_done) begin
      rx_data_d = shift_q;
      par_err_d = (PARITY_EN != 0) ? par_bad_q : 1'b0;
      frm_err_d = frm_d;
      rdy_d     = 1'b1;
      if (rdy_q) begin
        overrun_d = 1'b1;
      end
    end else if (clr_rdy && rdy_q) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboarded bench for uart_rx_param. Four receivers with different
// configurations share one clock:
//   0: defaults (2604-cycle bits, 8N1)
//   1: 32-cycle bits, 8 data, even parity, 1 stop
//   2: 16-cycle bits, 7 data, no parity, 2 stop
//   3: 32-cycle bits, 8N1
// The stimulus pushes the expected frame into a per-receiver queue; a
// monitor pops and compares whenever a receiver presents a frame.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_x;
  logic rx_line [4];
  logic clr     [4];
  logic rdy_o   [4];
  logic par_o   [4];
  logic frm_o   [4];
  logic ovr_o   [4];
  logic [7:0] a_data, p_data, d_data;
  logic [6:0] c_data;

  uart_rx_param u_a (
    .clk(clk), .sys_rst_n(rst_n_a), .uart_rx(rx_line[0]), .clr_rdy(clr[0]),
    .rx_data(a_data), .rdy(rdy_o[0]), .par_err(par_o[0]), .frm_err(frm_o[0]), .overrun(ovr_o[0])
  );

  uart_rx_param #(.BAUD_DIV(32), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .sys_rst_n(rst_n_x), .uart_rx(rx_line[1]), .clr_rdy(clr[1]),
    .rx_data(p_data), .rdy(rdy_o[1]), .par_err(par_o[1]), .frm_err(frm_o[1]), .overrun(ovr_o[1])
  );

  uart_rx_param #(.BAUD_DIV(16), .DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk(clk), .sys_rst_n(rst_n_x), .uart_rx(rx_line[2]), .clr_rdy(clr[2]),
    .rx_data(c_data), .rdy(rdy_o[2]), .par_err(par_o[2]), .frm_err(frm_o[2]), .overrun(ovr_o[2])
  );

  uart_rx_param #(.BAUD_DIV(32)) u_d (
    .clk(clk), .sys_rst_n(rst_n_x), .uart_rx(rx_line[3]), .clr_rdy(clr[3]),
    .rx_data(d_data), .rdy(rdy_o[3]), .par_err(par_o[3]), .frm_err(frm_o[3]), .overrun(ovr_o[3])
  );

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       frm;
    logic       ovr;
  } exp_t;

  exp_t exp_q [4][$];
  int   checks = 0;
  int   errors = 0;
  logic rdy_prev [4];
  logic ovr_prev [4];

  function automatic logic [8:0] data_of(input int id);
    case (id)
      0:       return 9'(a_data);
      1:       return 9'(p_data);
      2:       return 9'(c_data);
      default: return 9'(d_data);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_out(input int id);
    exp_t e;
    checks++;
    if (exp_q[id].size() == 0) begin
      errors++;
      $display("FAIL unexpected_frame dut%0d: got data=%0h with no frame outstanding", id, data_of(id));
    end else begin
      e = exp_q[id].pop_front();
      if ({data_of(id), par_o[id], frm_o[id], ovr_o[id]} !== {e.data, e.par, e.frm, e.ovr}) begin
        errors++;
        $display("FAIL frame dut%0d: got data=%0h par=%b frm=%b ovr=%b, expected data=%0h par=%b frm=%b ovr=%b",
                 id, data_of(id), par_o[id], frm_o[id], ovr_o[id], e.data, e.par, e.frm, e.ovr);
      end
    end
  endtask

  // A frame is presented when rdy rises, or when overrun rises while rdy
  // is already high (a second frame landed on top of the first).
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rdy_o[i] && (!rdy_prev[i] || (ovr_o[i] && !ovr_prev[i]))) begin
        check_out(i);
      end
      rdy_prev[i] <= rdy_o[i];
      ovr_prev[i] <= ovr_o[i];
    end
  end

  task automatic drive_bits(input int id, input int baud, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_line[id] = bits[i];
      repeat (baud) @(negedge clk);
    end
  endtask

  // Reference model: frame contents from the line rules, even parity
  // where parity is enabled (the only parity receiver is even).
  task automatic tx(input int id, input int baud, input int nbits, input logic [8:0] data,
                    input bit par_en, input bit par_bit, input int nstop,
                    input logic [1:0] stops, input bit ovr);
    logic [15:0] bits;
    logic [8:0]  mask;
    int          n;
    exp_t        e;
    mask   = 9'((1 << nbits) - 1);
    e.data = data & mask;
    e.par  = par_en && (par_bit != (^e.data));
    e.frm  = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    e.ovr  = ovr;
    exp_q[id].push_back(e);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (par_en) begin
      bits[n] = par_bit;
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stops[i];
      n++;
    end
    @(negedge clk);
    drive_bits(id, baud, bits, n);
    rx_line[id] = 1'b1;
    repeat (2 * baud) @(negedge clk);
  endtask

  task automatic clr_out(input int id, input string name);
    @(negedge clk);
    clr[id] = 1'b1;
    @(negedge clk);
    clr[id] = 1'b0;
    chk({name, "_rdy_cleared"}, 32'(rdy_o[id]), 32'd0);
    chk({name, "_ovr_cleared"}, 32'(ovr_o[id]), 32'd0);
  endtask

  task automatic chk_zero(input int id, input string name);
    chk({name, "_rdy"},  32'(rdy_o[id]),   32'd0);
    chk({name, "_data"}, 32'(data_of(id)), 32'd0);
    chk({name, "_par"},  32'(par_o[id]),   32'd0);
    chk({name, "_frm"},  32'(frm_o[id]),   32'd0);
    chk({name, "_ovr"},  32'(ovr_o[id]),   32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    bit         pb;
    logic [1:0] st;
    for (int i = 0; i < 4; i++) begin
      rx_line[i] = 1'b1;
      clr[i]     = 1'b0;
    end
    rst_n_a = 1'b0;
    rst_n_x = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(3, "reset_d");
    rst_n_a = 1'b1;
    rst_n_x = 1'b1;
    repeat (5) @(negedge clk);

    fork
      begin : thread_default
        tx(0, 2604, 8, 9'h0A5, 0, 0, 1, 2'b11, 0);
        chk("a_rdy_after_frame", 32'(rdy_o[0]), 32'd1);
        chk("a_par_zero", 32'(par_o[0]), 32'd0);
        clr_out(0, "a_first");
        rx_line[0] = 1'b0;
        repeat (500) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (3000) @(negedge clk);
        chk("a_glitch_no_rdy", 32'(rdy_o[0]), 32'd0);
        tx(0, 2604, 8, 9'h0A5, 0, 0, 1, 2'b11, 0);
        clr_out(0, "a_after_glitch");
      end
      begin : thread_small
        // even parity receiver
        tx(1, 32, 8, 9'h093, 1, 0, 1, 2'b11, 0);
        clr_out(1, "p_good");
        tx(1, 32, 8, 9'h093, 1, 1, 1, 2'b11, 0);
        clr_out(1, "p_bad");
        for (int k = 0; k < 6; k++) begin
          d  = 9'($urandom_range(0, 255));
          pb = 1'($urandom_range(0, 1));
          st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
          tx(1, 32, 8, d, 1, pb, 1, st, 0);
          clr_out(1, "p_rand");
        end
        // 7 data bits, 2 stop bits, 16-cycle bits
        tx(2, 16, 7, 9'h055, 0, 0, 2, 2'b11, 0);
        chk("c_par_zero", 32'(par_o[2]), 32'd0);
        clr_out(2, "c_55");
        for (int k = 0; k < 6; k++) begin
          d  = 9'($urandom_range(0, 127));
          st = 2'($urandom_range(0, 3));
          tx(2, 16, 7, d, 0, 0, 2, st, 0);
          clr_out(2, "c_rand");
        end
        // 8N1 receiver: framing, overrun, random, reset mid-frame
        tx(3, 32, 8, 9'h03C, 0, 0, 1, 2'b10, 0);
        clr_out(3, "d_frm");
        tx(3, 32, 8, 9'h05A, 0, 0, 1, 2'b11, 0);
        clr_out(3, "d_clean");
        tx(3, 32, 8, 9'h0A5, 0, 0, 1, 2'b11, 0);
        tx(3, 32, 8, 9'h093, 0, 0, 1, 2'b11, 1);
        clr_out(3, "d_overrun");
        for (int k = 0; k < 6; k++) begin
          d  = 9'($urandom_range(0, 255));
          st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
          tx(3, 32, 8, d, 0, 0, 1, st, 0);
          clr_out(3, "d_rand");
        end
        tx(3, 32, 8, 9'h03C, 0, 0, 1, 2'b10, 0);
        chk("d_held_before_reset", 32'(rdy_o[3]), 32'd1);
        // start bit plus data bits 0..3 low, reset halfway through bit 4
        @(negedge clk);
        drive_bits(3, 32, 16'h0000, 5);
        rx_line[3] = 1'b1;
        repeat (16) @(negedge clk);
        rst_n_x = 1'b0;
        #1;
        chk_zero(3, "d_midframe_reset");
        repeat (3) @(negedge clk);
        rst_n_x = 1'b1;
        repeat (64) @(negedge clk);
        chk("d_no_frame_after_reset", 32'(rdy_o[3]), 32'd0);
        tx(3, 32, 8, 9'h00F, 0, 0, 1, 2'b11, 0);
        clr_out(3, "d_after_reset");
      end
    join

    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_dut%0d", i), 32'(exp_q[i].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
